// File: rtl/id_ex_stage_pkg.sv
// Shared widths, register-zero constant and the control bundle that crosses the ID/EX boundary.
package id_ex_stage_pkg;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OPW = 4;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
        logic           mem_to_reg;
        logic           alu_src;
        logic [OPW-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Two-source forwarding mux: port 1 beats port 2, register zero is never forwarded.
module fwd_sel
    import id_ex_stage_pkg::*;
#(
    parameter int DW = id_ex_stage_pkg::DW,
    parameter int AW = id_ex_stage_pkg::AW
) (
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_base,
    input  logic          i_p1_we,
    input  logic [AW-1:0] i_p1_rd,
    input  logic [DW-1:0] i_p1_data,
    input  logic          i_p2_we,
    input  logic [AW-1:0] i_p2_rd,
    input  logic [DW-1:0] i_p2_data,
    output logic [DW-1:0] o_data
);
    logic w_nz;
    logic w_p1_hit;
    logic w_p2_hit;

    assign w_nz     = (i_addr != AW'(REG_ZERO));
    assign w_p1_hit = w_nz && i_p1_we && (i_p1_rd == i_addr);
    assign w_p2_hit = w_nz && i_p2_we && (i_p2_rd == i_addr);

    always_comb begin
        o_data = i_base;
        if (w_p1_hit)      o_data = i_p1_data;
        else if (w_p2_hit) o_data = i_p2_data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: write-through capture, EX-side operand forwarding and load-use stall.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW  = id_ex_stage_pkg::DW,
    parameter int AW  = id_ex_stage_pkg::AW,
    parameter int OPW = id_ex_stage_pkg::OPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [AW-1:0]  rs,
    input  logic [AW-1:0]  rt,
    input  logic [AW-1:0]  rd,
    input  logic           uses_rt,
    input  logic [DW-1:0]  read_data1,
    input  logic [DW-1:0]  read_data2,
    input  logic [DW-1:0]  imm,
    input  logic           reg_write_in,
    input  logic           mem_read_in,
    input  logic           mem_write_in,
    input  logic           mem_to_reg_in,
    input  logic           alu_src_in,
    input  logic [OPW-1:0] alu_op_in,
    input  logic           flush,
    input  logic           exmem_reg_write,
    input  logic [AW-1:0]  exmem_rd,
    input  logic [DW-1:0]  exmem_result,
    input  logic           memwb_reg_write,
    input  logic [AW-1:0]  memwb_rd,
    input  logic [DW-1:0]  memwb_data,
    output logic           hazard_stall,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_a,
    output logic [DW-1:0]  ex_b,
    output logic [DW-1:0]  ex_imm,
    output logic [AW-1:0]  ex_rd,
    output logic [AW-1:0]  ex_rs,
    output logic [AW-1:0]  ex_rt,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic           ex_mem_to_reg,
    output logic           ex_alu_src,
    output logic [OPW-1:0] ex_alu_op
);
    logic          r_valid;
    ctrl_t         r_ctrl;
    logic [DW-1:0] r_a, r_b, r_imm;
    logic [AW-1:0] r_rs, r_rt, r_rd;

    ctrl_t         w_ctrl_in;
    logic [DW-1:0] w_cap_a, w_cap_b;
    logic          w_bubble;

    assign w_ctrl_in = '{reg_write:  reg_write_in,
                         mem_read:   mem_read_in,
                         mem_write:  mem_write_in,
                         mem_to_reg: mem_to_reg_in,
                         alu_src:    alu_src_in,
                         alu_op:     alu_op_in};

    assign hazard_stall = in_valid && r_valid && r_ctrl.mem_read && (r_rd != AW'(REG_ZERO)) &&
                          ((r_rd == rs) || (uses_rt && (r_rd == rt)));

    assign w_bubble = flush || hazard_stall || !in_valid;

    // The register file returns the old value during a same-cycle write, so bypass MEM/WB here.
    fwd_sel #(.DW(DW), .AW(AW)) u_wt_a (
        .i_addr(rs), .i_base(read_data1),
        .i_p1_we(1'b0), .i_p1_rd('0), .i_p1_data('0),
        .i_p2_we(memwb_reg_write), .i_p2_rd(memwb_rd), .i_p2_data(memwb_data),
        .o_data(w_cap_a)
    );

    fwd_sel #(.DW(DW), .AW(AW)) u_wt_b (
        .i_addr(rt), .i_base(read_data2),
        .i_p1_we(1'b0), .i_p1_rd('0), .i_p1_data('0),
        .i_p2_we(memwb_reg_write), .i_p2_rd(memwb_rd), .i_p2_data(memwb_data),
        .o_data(w_cap_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
        end else if (w_bubble) begin
            // Data fields hold their old values to avoid needless toggling.
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl_in;
            r_a     <= w_cap_a;
            r_b     <= w_cap_b;
            r_imm   <= imm;
            r_rs    <= rs;
            r_rt    <= rt;
            r_rd    <= rd;
        end
    end

    fwd_sel #(.DW(DW), .AW(AW)) u_fwd_a (
        .i_addr(r_rs), .i_base(r_a),
        .i_p1_we(exmem_reg_write), .i_p1_rd(exmem_rd), .i_p1_data(exmem_result),
        .i_p2_we(memwb_reg_write), .i_p2_rd(memwb_rd), .i_p2_data(memwb_data),
        .o_data(ex_a)
    );

    fwd_sel #(.DW(DW), .AW(AW)) u_fwd_b (
        .i_addr(r_rt), .i_base(r_b),
        .i_p1_we(exmem_reg_write), .i_p1_rd(exmem_rd), .i_p1_data(exmem_result),
        .i_p2_we(memwb_reg_write), .i_p2_rd(memwb_rd), .i_p2_data(memwb_data),
        .o_data(ex_b)
    );

    assign ex_valid      = r_valid;
    assign ex_imm        = r_imm;
    assign ex_rd         = r_rd;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_alu_op     = r_ctrl.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand sequences, then random run against a model.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, uses_rt, flush;
    logic [4:0]  rs, rt, rd, exmem_rd, memwb_rd;
    logic [31:0] read_data1, read_data2, imm, exmem_result, memwb_data;
    logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, alu_src_in;
    logic [3:0]  alu_op_in;
    logic        exmem_reg_write, memwb_reg_write;
    logic        hazard_stall, ex_valid;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rd, ex_rs, ex_rt;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]  ex_alu_op;

    int total = 0;
    int bad   = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rs(rs), .rt(rt), .rd(rd), .uses_rt(uses_rt),
        .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .alu_src_in(alu_src_in), .alu_op_in(alu_op_in),
        .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [4:0] rs, rt, rd; logic ut; logic [31:0] d1, d2;
        logic rw, mr, fl;
        logic xw; logic [4:0] xrd; logic [31:0] xres;
        logic ww; logic [4:0] wrd; logic [31:0] wdat;
        logic e_st, e_v; logic [31:0] e_a, e_b; logic [4:0] e_rd; logic e_rw, e_mr;
    } vec_t;

    // Reference model of the EX slot contents.
    logic        m_v, m_rw, m_mr, m_mw, m_mtr, m_as;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        in_valid = 0; rs = 0; rt = 0; rd = 0; uses_rt = 0; read_data1 = 0; read_data2 = 0; imm = 0;
        reg_write_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0; alu_src_in = 0;
        alu_op_in = 0; flush = 0; exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    // Newest value of register r as seen by a reader whose stale copy is base.
    function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] base,
                                           input logic use_exmem);
        if (r == 0) return base;
        if (use_exmem && exmem_reg_write && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd == r) return memwb_data;
        return base;
    endfunction

    vec_t tbl[14];

    initial begin
        idle();
        rst = 1;
        in_valid = 1; rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        read_data1 = $urandom; read_data2 = $urandom; imm = $urandom; mem_read_in = 1;
        exmem_reg_write = 1; exmem_rd = 5'($urandom); exmem_result = $urandom;
        memwb_reg_write = 1; memwb_rd = 5'($urandom); memwb_data = $urandom;
        @(posedge clk); @(negedge clk); #1;
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_a", ex_a, 0);
        chk("rst_b", ex_b, 0);
        chk("rst_rd", 32'(ex_rd), 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op}, 0);
        chk("rst_stall", 32'(hazard_stall), 0);
        idle();
        rst = 0;

        //          v rs rt rd ut d1 d2 rw mr fl xw xrd xres ww wrd wdat st ev a b rd rw mr
        tbl[0]  = '{1,3,0,5,0,32'h11,32'h22,1,0,0, 0,0,0, 0,0,0, 0,1,32'h11,32'h22,5,1,0};
        tbl[1]  = '{1,4,6,8,1,32'hDEAD,32'h66,1,0,0, 0,0,0, 1,4,32'hBEEF, 0,1,32'hBEEF,32'h66,8,1,0};
        tbl[2]  = '{1,1,2,9,1,32'h100,32'h200,1,1,0, 0,0,0, 0,0,0, 0,1,32'h100,32'h200,9,1,1};
        tbl[3]  = '{1,10,9,11,1,32'h300,32'h400,1,0,0, 0,0,0, 0,0,0, 1,0,32'h100,32'h200,9,0,0};
        tbl[4]  = '{1,10,9,11,1,32'h300,32'h400,1,0,0, 0,0,0, 0,0,0, 0,1,32'h300,32'h400,11,1,0};
        tbl[5]  = '{1,1,2,12,1,32'h500,32'h600,1,1,0, 0,0,0, 0,0,0, 0,1,32'h500,32'h600,12,1,1};
        tbl[6]  = '{1,3,12,13,0,32'h700,32'h800,1,0,0, 0,0,0, 0,0,0, 0,1,32'h700,32'h800,13,1,0};
        tbl[7]  = '{1,1,2,0,1,32'h900,32'hA00,1,1,0, 0,0,0, 0,0,0, 0,1,32'h900,32'hA00,0,1,1};
        tbl[8]  = '{1,0,0,14,1,32'hB00,32'hC00,1,0,0, 1,0,32'hFFFF, 0,0,0, 0,1,32'hB00,32'hC00,14,1,0};
        tbl[9]  = '{1,1,2,15,1,32'hD00,32'hD01,1,0,1, 0,0,0, 0,0,0, 0,0,32'hB00,32'hC00,14,0,0};
        tbl[10] = '{1,1,2,16,1,32'hE00,32'hF00,1,1,0, 0,0,0, 0,0,0, 0,1,32'hE00,32'hF00,16,1,1};
        tbl[11] = '{1,16,2,17,1,32'h1000,32'h2000,1,0,1, 0,0,0, 0,0,0, 1,0,32'hE00,32'hF00,16,0,0};
        tbl[12] = '{1,16,0,17,0,32'h1000,32'h2000,1,0,0, 0,0,0, 0,0,0, 0,1,32'h1000,32'h2000,17,1,0};
        tbl[13] = '{0,5,5,5,1,32'h1,32'h2,1,1,0, 0,0,0, 0,0,0, 0,0,32'h1000,32'h2000,17,0,0};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v; rs = tbl[i].rs; rt = tbl[i].rt; rd = tbl[i].rd; uses_rt = tbl[i].ut;
            read_data1 = tbl[i].d1; read_data2 = tbl[i].d2; reg_write_in = tbl[i].rw;
            mem_read_in = tbl[i].mr; flush = tbl[i].fl;
            exmem_reg_write = tbl[i].xw; exmem_rd = tbl[i].xrd; exmem_result = tbl[i].xres;
            memwb_reg_write = tbl[i].ww; memwb_rd = tbl[i].wrd; memwb_data = tbl[i].wdat;
            #1 chk($sformatf("v%0d_stall", i), 32'(hazard_stall), 32'(tbl[i].e_st));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(tbl[i].e_v));
            chk($sformatf("v%0d_a", i), ex_a, tbl[i].e_a);
            chk($sformatf("v%0d_b", i), ex_b, tbl[i].e_b);
            chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d_rw", i), 32'(ex_reg_write), 32'(tbl[i].e_rw));
            chk($sformatf("v%0d_mr", i), 32'(ex_mem_read), 32'(tbl[i].e_mr));
        end

        // EX forwarding priority on a latched instruction.
        @(negedge clk);
        idle(); in_valid = 1; rs = 7; rt = 8; rd = 3; read_data1 = 32'h77; read_data2 = 32'h88;
        @(posedge clk); #1;
        in_valid = 0;
        exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'hAAAA;
        memwb_reg_write = 1; memwb_rd = 7; memwb_data = 32'hBBBB;
        #1 chk("fwd_exmem_wins", ex_a, 32'hAAAA);
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", ex_a, 32'hBBBB);
        memwb_rd = 0;
        #1 chk("fwd_none", ex_a, 32'h77);
        memwb_rd = 8;
        #1 chk("fwd_b_memwb", ex_b, 32'hBBBB);

        // Reset arriving while a stall is asserted.
        @(negedge clk);
        idle(); in_valid = 1; rs = 1; rt = 2; rd = 9; mem_read_in = 1; reg_write_in = 1;
        @(posedge clk); #1;
        idle(); in_valid = 1; rs = 9; rd = 4;
        #1 chk("midrst_stall_before", 32'(hazard_stall), 1);
        rst = 1;
        #1 chk("midrst_stall_after", 32'(hazard_stall), 0);
        chk("midrst_valid", 32'(ex_valid), 0);
        chk("midrst_mr", 32'(ex_mem_read), 0);
        @(negedge clk);
        rst = 0; idle();

        m_v = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_as = 0; m_op = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;

        for (int c = 0; c < 400; c++) begin
            logic exp_st;
            @(negedge clk);
            in_valid = ($urandom_range(0, 4) != 0);
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
            uses_rt = 1'($urandom); read_data1 = $urandom; read_data2 = $urandom; imm = $urandom;
            reg_write_in = 1'($urandom); mem_read_in = ($urandom_range(0, 2) == 0);
            mem_write_in = 1'($urandom); mem_to_reg_in = 1'($urandom); alu_src_in = 1'($urandom);
            alu_op_in = 4'($urandom); flush = ($urandom_range(0, 7) == 0);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
            exp_st = in_valid && m_v && m_mr && m_rd != 0 && (m_rd == rs || (uses_rt && m_rd == rt));
            #1;
            chk("rnd_stall", 32'(hazard_stall), 32'(exp_st));
            chk("rnd_a", ex_a, newest(m_rs, m_a, 1));
            chk("rnd_b", ex_b, newest(m_rt, m_b, 1));
            chk("rnd_valid", 32'(ex_valid), 32'(m_v));
            chk("rnd_rd", 32'(ex_rd), 32'(m_rd));
            chk("rnd_imm", ex_imm, m_imm);
            chk("rnd_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op},
                {m_rw, m_mr, m_mw, m_mtr, m_as, m_op});
            if (flush || exp_st || !in_valid) begin
                m_v = 0; {m_rw, m_mr, m_mw, m_mtr, m_as, m_op} = '0;
            end else begin
                m_v = 1; m_rw = reg_write_in; m_mr = mem_read_in; m_mw = mem_write_in;
                m_mtr = mem_to_reg_in; m_as = alu_src_in; m_op = alu_op_in;
                m_a = newest(rs, read_data1, 0); m_b = newest(rt, read_data2, 0);
                m_imm = imm; m_rs = rs; m_rt = rt; m_rd = rd;
            end
            @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the 32x32 register file.
- Latches the register-file read data, immediate, destination and control bits into the ID/EX boundary.
- Applies two kinds of bypass:
  - Write-through bypass at capture, because the register file returns stale data during a same-cycle write.
  - EX-side forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, stalls decode and inserts a bubble.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.
- OPW, 4, ALU opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode slot holds a real instruction.
- rs, rt, rd  in  AW  source and destination register numbers.
- uses_rt  in  1  instruction actually reads rt (R-type, store, branch).
- read_data1, read_data2  in  DW  register-file outputs for rs and rt.
- imm  in  DW  sign-extended immediate.
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, alu_src_in  in  1 each  control bits.
- alu_op_in  in  OPW  ALU opcode.
- flush  in  1  branch taken or redirect; kill the decode slot.
- exmem_reg_write  in  1  EX/MEM stage writes a register.
- exmem_rd  in  AW  EX/MEM destination register.
- exmem_result  in  DW  EX/MEM result value.
- memwb_reg_write  in  1  MEM/WB stage writes a register.
- memwb_rd  in  AW  MEM/WB destination register.
- memwb_data  in  DW  MEM/WB write-back data; same signals drive the register-file write port.
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_a, ex_b  out  DW  forwarded operands, combinational from latched state.
- ex_imm  out  DW  latched immediate.
- ex_rd  out  AW  latched destination register.
- ex_rs, ex_rt  out  AW  latched source register numbers.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  latched control bits.
- ex_alu_op  out  OPW  latched ALU opcode.

Behaviour:
- Reset (async, rst=1): every registered output clears to 0, including ex_valid, data, addresses and control. Ports ex_a, ex_b and hazard_stall are combinational and therefore also read 0.
- Latency: one clk from decode inputs to ex_* outputs.
- Load-use hazard:
  - hazard_stall = in_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==rs) | (uses_rt & ex_rd==rt)).
- Per-edge update priority:
  1. rst.
  2. flush → bubble.
  3. hazard_stall → bubble.
  4. in_valid → capture.
  5. Otherwise → bubble.
- Bubble: ex_valid=0 and all control bits 0. Data fields are don't-care; they are held at their previous values to save toggles.
- Capture write-through: operand A = (memwb_reg_write & memwb_rd!=0 & memwb_rd==rs) ? memwb_data : read_data1. Operand B is the same rule with rt and read_data2.
- EX forwarding on ex_a:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs → exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs → memwb_data.
  - Else latched A.
  - EX/MEM always wins when both stages match.
- EX forwarding on ex_b: same rule using ex_rt. ex_b is the forwarded register value; the ALU-src mux is outside this block.
- Register 0: never forwarded and never triggers a stall.
- flush together with a hazard: flush wins. hazard_stall still asserts combinationally; upstream treats flush as dominant.
- Stall lasts exactly one cycle per load-use pair, because the bubble clears ex_mem_read on the next cycle.
- rst mid-stall: state clears immediately and hazard_stall drops in the same cycle.
- No arithmetic in this block; all compares are AW-bit equality.

Decomposition:
- Shared package: DW, AW, OPW, the REG_ZERO constant, and a ctrl struct/bundle. The bundle holds reg_write, mem_read, mem_write, mem_to_reg, alu_src and alu_op, so the bubble is a single all-zero constant.
- One sub-module, fwd_sel: a 2-source forwarding comparator/mux, instantiated twice (A and B) for EX forwarding and reused for the write-through bypass.
- Hazard logic stays inline.

Test Plan:
- Reset: assert rst with random inputs → all ex_* = 0, hazard_stall = 0. Deassert; in_valid=1, rs=3, read_data1=0x11, rd=5, reg_write_in=1 → next cycle ex_valid=1, ex_a=0x11, ex_rd=5.
- Write-through: rs=4, read_data1=0xDEAD, memwb_reg_write=1, memwb_rd=4, memwb_data=0xBEEF → next cycle ex_a=0xBEEF.
- EX forwarding priority: ex_rs=7; exmem_rd=7 with result 0xAAAA and memwb_rd=7 with data 0xBBBB, both writing → ex_a=0xAAAA. Drop exmem_reg_write → ex_a=0xBBBB. Set memwb_rd=0 → ex_a=latched value.
- Load-use: EX holds a load with ex_rd=9; decode rt=9, uses_rt=1 → hazard_stall=1 and next cycle ex_valid=0. The same instruction presented again → captured with hazard_stall=0. Repeat with uses_rt=0 → no stall.
- Register 0: load with ex_rd=0 and rs=0 → no stall. exmem_rd=0, exmem_reg_write=1 → no forwarding.
- Flush: flush=1 with in_valid=1 → ex_valid=0 and all control 0. Flush during an active hazard → bubble, and the pipeline recovers on the next valid instruction.
